// File: rtl/bus_addr_dec_seq_pkg.sv
// Shared types and defaults for the registered bus address decoder.
// State encoding, default region map and error counter helpers.
package bus_addr_dec_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEL  = 1'b1
    } state_t;

    localparam int ERR_CNT_W = 8;
    localparam int TO_CNT_W  = 8;

    localparam logic [15:0] DEF_SLV_LO = {4'h4, 4'h2, 4'h1, 4'h0};
    localparam logic [15:0] DEF_SLV_HI = {4'h5, 4'h3, 4'h1, 4'h0};

    function automatic logic [ERR_CNT_W-1:0] sat_inc(
        input logic [ERR_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bus_region_match.sv
// Region range compare and priority encode for the address decoder.
// Lowest slave index wins when ranges overlap.
module bus_region_match #(
    parameter int                         NUM_SLV = 4,
    parameter int                         REG_W   = 4,
    parameter int                         IDX_W   = 2,
    parameter logic [NUM_SLV*REG_W-1:0]   SLV_LO  = '0,
    parameter logic [NUM_SLV*REG_W-1:0]   SLV_HI  = '0
) (
    input  logic [REG_W-1:0] region,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest matching slave is written last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (region >= SLV_LO[i*REG_W +: REG_W] &&
                region <= SLV_HI[i*REG_W +: REG_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_addr_dec_seq.sv
// Registered bus address decoder with held slave select and error capture.
// Optional ack timeout enabled by defining BUS_ADDR_DEC_TIMEOUT_EN.
module bus_addr_dec_seq
    import bus_addr_dec_seq_pkg::*;
#(
    parameter int                         ADDR_W  = 8,
    parameter int                         REG_W   = 4,
    parameter int                         NUM_SLV = 4,
    parameter logic [NUM_SLV*REG_W-1:0]   SLV_LO  = DEF_SLV_LO,
    parameter logic [NUM_SLV*REG_W-1:0]   SLV_HI  = DEF_SLV_HI,
    parameter int                         TO_CYC  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_req,
    input  logic [ADDR_W-1:0]    m_addr,
    output logic                 m_ready,
    output logic                 m_err,
    output logic [NUM_SLV-1:0]   s_sel,
    input  logic [NUM_SLV-1:0]   s_ack,
    output logic                 busy,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    state_t                 state, state_nxt;
    logic [NUM_SLV-1:0]     sel_nxt;
    logic                   busy_nxt;
    logic                   rdy_nxt;
    logic                   err_nxt;
    logic [ADDR_W-1:0]      eaddr_nxt;
    logic [ERR_CNT_W-1:0]   ecnt_nxt;
    logic [ADDR_W-1:0]      addr_q, addr_nxt;
    logic [IDX_W-1:0]       idx_q, idx_nxt;
    logic                   hit;
    logic [IDX_W-1:0]       match_idx;

`ifdef BUS_ADDR_DEC_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LIM = TO_CNT_W'(TO_CYC - 1);
    logic [TO_CNT_W-1:0]    to_cnt, to_nxt;
`endif

    bus_region_match #(
        .NUM_SLV (NUM_SLV),
        .REG_W   (REG_W),
        .IDX_W   (IDX_W),
        .SLV_LO  (SLV_LO),
        .SLV_HI  (SLV_HI)
    ) u_match (
        .region (m_addr[ADDR_W-1 -: REG_W]),
        .hit    (hit),
        .idx    (match_idx)
    );

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_nxt = state;
        sel_nxt   = s_sel;
        busy_nxt  = busy;
        rdy_nxt   = 1'b0;
        err_nxt   = 1'b0;
        eaddr_nxt = err_addr;
        ecnt_nxt  = err_cnt;
        addr_nxt  = addr_q;
        idx_nxt   = idx_q;
`ifdef BUS_ADDR_DEC_TIMEOUT_EN
        to_nxt    = to_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (m_req) begin
                    if (hit) begin
                        state_nxt = SEL;
                        sel_nxt   = NUM_SLV'(1) << match_idx;
                        busy_nxt  = 1'b1;
                        addr_nxt  = m_addr;
                        idx_nxt   = match_idx;
`ifdef BUS_ADDR_DEC_TIMEOUT_EN
                        to_nxt    = '0;
`endif
                    end else begin
                        rdy_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                        eaddr_nxt = m_addr;
                        ecnt_nxt  = sat_inc(err_cnt);
                    end
                end
            end
            SEL: begin
                if (s_ack[idx_q]) begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    busy_nxt  = 1'b0;
                    rdy_nxt   = 1'b1;
                end else begin
`ifdef BUS_ADDR_DEC_TIMEOUT_EN
                    if (to_cnt == TO_LIM) begin
                        state_nxt = IDLE;
                        sel_nxt   = '0;
                        busy_nxt  = 1'b0;
                        rdy_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                        eaddr_nxt = addr_q;
                        ecnt_nxt  = sat_inc(err_cnt);
                    end else begin
                        to_nxt = to_cnt + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            s_sel    <= '0;
            busy     <= 1'b0;
            m_ready  <= 1'b0;
            m_err    <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
            addr_q   <= '0;
            idx_q    <= '0;
`ifdef BUS_ADDR_DEC_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            state    <= state_nxt;
            s_sel    <= sel_nxt;
            busy     <= busy_nxt;
            m_ready  <= rdy_nxt;
            m_err    <= err_nxt;
            err_addr <= eaddr_nxt;
            err_cnt  <= ecnt_nxt;
            addr_q   <= addr_nxt;
            idx_q    <= idx_nxt;
`ifdef BUS_ADDR_DEC_TIMEOUT_EN
            to_cnt   <= to_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_bus_addr_dec_seq.sv
// Testbench for bus_addr_dec_seq: directed cases plus random traffic
// checked against a transaction-level reference model.
module tb_bus_addr_dec_seq;

    localparam int TO_CYC = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       m_req;
    logic [7:0] m_addr;
    logic [3:0] s_ack;
    logic       m_ready;
    logic       m_err;
    logic [3:0] s_sel;
    logic       busy;
    logic [7:0] err_addr;
    logic [7:0] err_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // Reference region map, slave i covers regions lo[i]..hi[i].
    int lo[4] = '{0, 1, 2, 4};
    int hi[4] = '{0, 1, 3, 5};

    // Reference model state.
    bit         mb;
    int         mk;
    logic [7:0] ma;
    logic [7:0] mea;
    int         mcnt;
    int         mwait;
    bit         erdy;
    bit         eerr;

    bus_addr_dec_seq #(
        .TO_CYC (TO_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .s_sel    (s_sel),
        .s_ack    (s_ack),
        .busy     (busy),
        .err_addr (err_addr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    function automatic int decode(input logic [7:0] a);
        int r;
        r = int'(a[7:4]);
        for (int i = 0; i < 4; i++)
            if (r >= lo[i] && r <= hi[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] exp_sel();
        return mb ? 4'(1 << mk) : 4'b0000;
    endfunction

    task automatic model_reset();
        mb = 0; mk = 0; ma = '0; mea = '0;
        mcnt = 0; mwait = 0; erdy = 0; eerr = 0;
    endtask

    task automatic log_error(input logic [7:0] a);
        erdy = 1;
        eerr = 1;
        mea  = a;
        if (mcnt < 255) mcnt++;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int k;
        erdy = 0;
        eerr = 0;
        if (!mb) begin
            if (m_req) begin
                k = decode(m_addr);
                if (k >= 0) begin
                    mb = 1; mk = k; ma = m_addr; mwait = 0;
                end else begin
                    log_error(m_addr);
                end
            end
        end else if (s_ack[mk]) begin
            mb   = 0;
            erdy = 1;
        end else begin
            mwait++;
`ifdef BUS_ADDR_DEC_TIMEOUT_EN
            if (mwait >= TO_CYC) begin
                mb = 0;
                log_error(ma);
            end
`endif
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".s_sel"},    32'(s_sel),    32'(exp_sel()));
        chk({tag, ".busy"},     32'(busy),     32'(mb));
        chk({tag, ".m_ready"},  32'(m_ready),  32'(erdy));
        chk({tag, ".m_err"},    32'(m_err),    32'(eerr));
        chk({tag, ".err_addr"}, 32'(err_addr), 32'(mea));
        chk({tag, ".err_cnt"},  32'(err_cnt),  32'(mcnt));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        reset  = 1'b1;
        m_req  = 1'b0;
        m_addr = '0;
        s_ack  = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Mapped transfer to slave 2, ack completes it.
        m_req = 1; m_addr = 8'h25;
        cycle("sel2");
        m_req = 0; s_ack = 4'b0100;
        cycle("ack2");
        s_ack = 0;
        cycle("idle2");

        // Unmapped region 7.
        m_req = 1; m_addr = 8'h73;
        cycle("unmap");
        m_req = 0;
        cycle("unmap_idle");

        // Foreign acks and address changes ignored while busy.
        m_req = 1; m_addr = 8'h05;
        cycle("sel0");
        m_req = 0; s_ack = 4'b1110;
        cycle("foreign_ack");
        m_addr = 8'h40;
        cycle("addr_change");
        s_ack = 4'b0001;
        cycle("ack0");
        s_ack = 0;
        cycle("idle0");

        // Back-to-back with immediate acks.
        m_req = 1; m_addr = 8'h10; s_ack = 4'b1010;
        cycle("b2b_sel1");
        m_addr = 8'h50;
        cycle("b2b_rdy1");
        cycle("b2b_sel3");
        m_req = 0;
        cycle("b2b_rdy3");
        s_ack = 0;
        cycle("b2b_idle");

        // Asynchronous reset mid-transfer.
        m_req = 1; m_addr = 8'h05;
        cycle("pre_rst");
        m_req = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst.s_sel", 32'(s_sel), 32'(0));
        chk("async_rst.busy", 32'(busy), 32'(0));
        chk("async_rst.m_ready", 32'(m_ready), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        cycle("post_rst1");
        cycle("post_rst2");

        // Error counter saturation.
        m_req = 1; m_addr = 8'hF0;
        repeat (260) cycle("sat");
        m_req = 0;
        cycle("sat_idle");

        // Slave 3 with no ack: timeout when enabled, otherwise waits.
        m_req = 1; m_addr = 8'h40;
        cycle("to_sel");
        m_req = 0;
        repeat (16) cycle("to_wait");
        // Ack arriving on the last allowed cycle.
        m_req = 1; m_addr = 8'h4C;
        cycle("to2_sel");
        m_req = 0;
        repeat (14) cycle("to2_wait");
        s_ack = 4'b1000;
        cycle("to2_ack");
        s_ack = 4'b1111;
        cycle("drain");
        s_ack = 0;
        cycle("drain_idle");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            m_req  = 1'($urandom_range(0, 1));
            m_addr = 8'($urandom);
            s_ack  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
